// File: rtl/integer_divider_pkg.sv
// Shared arithmetic-block package for the integer divider.
// Holds the default operand width and the divider FSM state encoding.
package integer_divider_pkg;

  localparam int unsigned DIV_OPERAND_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : integer_divider_pkg

// File: rtl/integer_divider_step.sv
// One restoring shift-subtract iteration (purely combinational).
//   partial_rem_in  : W+1-bit partial remainder, already shifted left with
//                     the next dividend bit in its LSB
//   divisor_in      : divisor magnitude
//   partial_rem_out : next partial remainder (always < divisor, fits W bits)
//   quotient_bit_out: 1 when the divisor was subtracted
module integer_divider_step
  import integer_divider_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH_IN_BITS = DIV_OPERAND_WIDTH_DEFAULT
) (
  input  logic [OPERAND_WIDTH_IN_BITS:0]   partial_rem_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] divisor_in,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] partial_rem_out,
  output logic                             quotient_bit_out
);

  localparam int unsigned W = OPERAND_WIDTH_IN_BITS;

  always_comb begin
    quotient_bit_out = (partial_rem_in >= {1'b0, divisor_in});
    // The true difference is below the divisor, so W-bit modular
    // subtraction gives the exact result and drops the carry bit.
    if (quotient_bit_out) begin
      partial_rem_out = partial_rem_in[W-1:0] - divisor_in;
    end else begin
      partial_rem_out = partial_rem_in[W-1:0];
    end
  end

endmodule : integer_divider_step

// File: rtl/integer_divider.sv
// Sign-magnitude restoring integer divider, one quotient bit per cycle.
// Ports:
//   clk_in, reset_in (sync, active high)
//   dividend_valid_in/sign/in, divisor_valid_in/sign/in : operands
//   issue_ack_out       : one-cycle pulse when operands are taken
//   quotient_valid_out  : result present (held until issue_ack_in)
//   quotient_sign/out, remainder_sign/out : sign-magnitude result
//   divide_exception_out: divisor was zero
//   issue_ack_in        : consumer takes the result (honoured in DONE only)
module integer_divider
  import integer_divider_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH_IN_BITS = DIV_OPERAND_WIDTH_DEFAULT
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             dividend_valid_in,
  input  logic                             dividend_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] dividend_in,
  input  logic                             divisor_valid_in,
  input  logic                             divisor_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0] divisor_in,
  output logic                             issue_ack_out,
  output logic                             quotient_valid_out,
  output logic                             quotient_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] quotient_out,
  output logic                             remainder_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] remainder_out,
  input  logic                             issue_ack_in,
  output logic                             divide_exception_out
);

  localparam int unsigned W  = OPERAND_WIDTH_IN_BITS;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  div_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;          // running partial remainder
  logic [W-1:0]   qd_q, qd_d;            // dividend bits out at MSB, quotient bits in at LSB
  logic [W-1:0]   divisor_q, divisor_d;
  logic           dsign_q, dsign_d;
  logic           vsign_q, vsign_d;

  logic           ack_q, ack_d;
  logic           valid_q, valid_d;
  logic           qsign_q, qsign_d;
  logic [W-1:0]   quot_q, quot_d;
  logic           rsign_q, rsign_d;
  logic [W-1:0]   remo_q, remo_d;
  logic           exc_q, exc_d;

  logic [W-1:0]   step_rem;
  logic           step_bit;
  logic [W-1:0]   qd_next;

  integer_divider_step #(
    .OPERAND_WIDTH_IN_BITS(W)
  ) u_step (
    .partial_rem_in  ({rem_q, qd_q[W-1]}),
    .divisor_in      (divisor_q),
    .partial_rem_out (step_rem),
    .quotient_bit_out(step_bit)
  );

  assign qd_next = {qd_q[W-2:0], step_bit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    qd_d      = qd_q;
    divisor_d = divisor_q;
    dsign_d   = dsign_q;
    vsign_d   = vsign_q;
    ack_d     = 1'b0;
    valid_d   = valid_q;
    qsign_d   = qsign_q;
    quot_d    = quot_q;
    rsign_d   = rsign_q;
    remo_d    = remo_q;
    exc_d     = exc_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (dividend_valid_in && divisor_valid_in) begin
          ack_d     = 1'b1;
          qd_d      = dividend_in;
          divisor_d = divisor_in;
          dsign_d   = dividend_sign_in;
          vsign_d   = divisor_sign_in;
          rem_d     = '0;
          cnt_d     = '0;
          if (divisor_in == '0) begin
            state_d = DIV_DONE;
            valid_d = 1'b1;
            exc_d   = 1'b1;
            quot_d  = '1;
            qsign_d = dividend_sign_in ^ divisor_sign_in;
            remo_d  = dividend_in;
            rsign_d = dividend_sign_in && (dividend_in != '0);
          end else begin
            state_d = DIV_RUN;
          end
        end
      end

      DIV_RUN: begin
        rem_d = step_rem;
        qd_d  = qd_next;
        cnt_d = cnt_q + CW'(1);
        // Final step: publish the combinational step result directly.
        if (cnt_q == LAST_ITER) begin
          state_d = DIV_DONE;
          valid_d = 1'b1;
          exc_d   = 1'b0;
          quot_d  = qd_next;
          qsign_d = (dsign_q ^ vsign_q) && (qd_next != '0);
          remo_d  = step_rem;
          rsign_d = dsign_q && (step_rem != '0);
        end
      end

      DIV_DONE: begin
        if (issue_ack_in) begin
          state_d = DIV_IDLE;
          valid_d = 1'b0;
          exc_d   = 1'b0;
          quot_d  = '0;
          qsign_d = 1'b0;
          remo_d  = '0;
          rsign_d = 1'b0;
        end
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      qd_q      <= '0;
      divisor_q <= '0;
      dsign_q   <= 1'b0;
      vsign_q   <= 1'b0;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      qsign_q   <= 1'b0;
      quot_q    <= '0;
      rsign_q   <= 1'b0;
      remo_q    <= '0;
      exc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      qd_q      <= qd_d;
      divisor_q <= divisor_d;
      dsign_q   <= dsign_d;
      vsign_q   <= vsign_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      qsign_q   <= qsign_d;
      quot_q    <= quot_d;
      rsign_q   <= rsign_d;
      remo_q    <= remo_d;
      exc_q     <= exc_d;
    end
  end

  assign issue_ack_out        = ack_q;
  assign quotient_valid_out   = valid_q;
  assign quotient_sign_out    = qsign_q;
  assign quotient_out         = quot_q;
  assign remainder_sign_out   = rsign_q;
  assign remainder_out        = remo_q;
  assign divide_exception_out = exc_q;

endmodule : integer_divider

// File: tb/tb_integer_divider.sv
module tb_integer_divider;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset_in;
  logic         dividend_valid_in, dividend_sign_in;
  logic [W-1:0] dividend_in;
  logic         divisor_valid_in, divisor_sign_in;
  logic [W-1:0] divisor_in;
  logic         issue_ack_out, quotient_valid_out, quotient_sign_out;
  logic [W-1:0] quotient_out, remainder_out;
  logic         remainder_sign_out, issue_ack_in, divide_exception_out;

  always #5 clk = ~clk;

  integer_divider #(.OPERAND_WIDTH_IN_BITS(W)) dut (
    .clk_in              (clk),
    .reset_in            (reset_in),
    .dividend_valid_in   (dividend_valid_in),
    .dividend_sign_in    (dividend_sign_in),
    .dividend_in         (dividend_in),
    .divisor_valid_in    (divisor_valid_in),
    .divisor_sign_in     (divisor_sign_in),
    .divisor_in          (divisor_in),
    .issue_ack_out       (issue_ack_out),
    .quotient_valid_out  (quotient_valid_out),
    .quotient_sign_out   (quotient_sign_out),
    .quotient_out        (quotient_out),
    .remainder_sign_out  (remainder_sign_out),
    .remainder_out       (remainder_out),
    .issue_ack_in        (issue_ack_in),
    .divide_exception_out(divide_exception_out)
  );

  typedef struct {
    logic [W-1:0] dd;
    logic         ds;
    logic [W-1:0] dv;
    logic         vs;
    logic [W-1:0] q;
    logic         qs;
    logic [W-1:0] r;
    logic         rs;
    logic         exc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ack"},   W'(issue_ack_out), '0);
    chk({tag, " valid"}, W'(quotient_valid_out), '0);
    chk({tag, " qsign"}, W'(quotient_sign_out), '0);
    chk({tag, " quot"},  quotient_out, '0);
    chk({tag, " rsign"}, W'(remainder_sign_out), '0);
    chk({tag, " rem"},   remainder_out, '0);
    chk({tag, " exc"},   W'(divide_exception_out), '0);
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, " valid"}, W'(quotient_valid_out), W'(1));
    chk({tag, " quot"},  quotient_out, v.q);
    chk({tag, " qsign"}, W'(quotient_sign_out), W'(v.qs));
    chk({tag, " rem"},   remainder_out, v.r);
    chk({tag, " rsign"}, W'(remainder_sign_out), W'(v.rs));
    chk({tag, " exc"},   W'(divide_exception_out), W'(v.exc));
  endtask

  // Present operands for one edge (E0); returns #1 after E0.
  task automatic issue(input vec_t v, input string tag);
    @(negedge clk);
    dividend_valid_in = 1'b1; dividend_sign_in = v.ds; dividend_in = v.dd;
    divisor_valid_in  = 1'b1; divisor_sign_in  = v.vs; divisor_in  = v.dv;
    @(posedge clk); #1;
    dividend_valid_in = 1'b0; divisor_valid_in = 1'b0;
    chk({tag, " issue_ack"}, W'(issue_ack_out), W'(1));
  endtask

  // Count further edges until the result appears; bounded.
  task automatic wait_result(input int exp_lat, input string tag);
    int k = 0;
    while (!quotient_valid_out && k < int'(W) + 10) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) chk({tag, " ack_pulse_end"}, W'(issue_ack_out), '0);
    end
    chk({tag, " latency"}, W'(k), W'(exp_lat));
  endtask

  task automatic take_result(input string tag);
    @(negedge clk); issue_ack_in = 1'b1;
    @(posedge clk); #1; issue_ack_in = 1'b0;
    chk_all_zero({tag, " cleared"});
  endtask

  function automatic vec_t mk(input logic [W-1:0] dd, input logic ds, input logic [W-1:0] dv,
                              input logic vs, input logic [W-1:0] q, input logic qs,
                              input logic [W-1:0] r, input logic rs, input logic exc);
    vec_t v;
    v.dd = dd; v.ds = ds; v.dv = dv; v.vs = vs;
    v.q = q; v.qs = qs; v.r = r; v.rs = rs; v.exc = exc;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    vec_t v;
    logic seen;
    logic [W-1:0] ones = '1;

    vecs[0]  = mk(100, 0, 7, 0, 14, 0, 2, 0, 0);
    vecs[1]  = mk(100, 1, 7, 0, 14, 1, 2, 1, 0);
    vecs[2]  = mk(100, 0, 7, 1, 14, 1, 2, 0, 0);
    vecs[3]  = mk(5, 0, 0, 0, ones, 0, 5, 0, 1);
    vecs[4]  = mk(9, 1, 0, 0, ones, 1, 9, 1, 1);
    vecs[5]  = mk(ones, 0, 1, 0, ones, 0, 0, 0, 0);
    vecs[6]  = mk(3, 0, 9, 0, 0, 0, 3, 0, 0);
    vecs[7]  = mk(3, 1, 9, 0, 0, 0, 3, 1, 0);
    vecs[8]  = mk(7, 1, 7, 1, 1, 0, 0, 0, 0);
    vecs[9]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(ones, 0, 64'h1_0000_0000, 0, 64'hFFFF_FFFF, 0, 64'hFFFF_FFFF, 0, 0);
    vecs[11] = mk(64'h8000_0000_0000_0000, 0, 3, 1, 64'h2AAA_AAAA_AAAA_AAAA, 1, 2, 0, 0);
    vecs[12] = mk(64'hFFFF_FFFF_FFFF_FFFE, 1, ones, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0);

    reset_in = 1'b1; issue_ack_in = 1'b0;
    dividend_valid_in = 1'b0; dividend_sign_in = 1'b0; dividend_in = '0;
    divisor_valid_in  = 1'b0; divisor_sign_in  = 1'b0; divisor_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); reset_in = 1'b0;

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      issue(vecs[i], tag);
      wait_result((vecs[i].dv == '0) ? 0 : int'(W), tag);
      chk_result(tag, vecs[i]);
      take_result(tag);
    end

    // Result holds while unacknowledged; operand activity is ignored.
    issue(vecs[0], "hold");
    wait_result(W, "hold");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dividend_valid_in = c[0]; divisor_valid_in = ~c[1];
      dividend_in = 64'(c + 1); divisor_in = 1;
      @(posedge clk); #1;
      chk($sformatf("hold%0d ack", c), W'(issue_ack_out), '0);
      chk_result($sformatf("hold%0d", c), vecs[0]);
    end
    dividend_valid_in = 1'b0; divisor_valid_in = 1'b0;
    take_result("hold");

    // issue_ack_in during RUN has no effect.
    v = mk(9, 0, 3, 0, 3, 0, 0, 0, 0);
    issue(v, "ackrun");
    @(negedge clk); issue_ack_in = 1'b1;
    repeat (3) @(posedge clk);
    #1; issue_ack_in = 1'b0;
    wait_result(W - 3, "ackrun");
    chk_result("ackrun", v);

    // Valids held across the acknowledging edge: accepted one edge later.
    v = mk(8, 0, 2, 0, 4, 0, 0, 0, 0);
    @(negedge clk);
    issue_ack_in = 1'b1;
    dividend_valid_in = 1'b1; dividend_sign_in = 1'b0; dividend_in = v.dd;
    divisor_valid_in  = 1'b1; divisor_sign_in  = 1'b0; divisor_in  = v.dv;
    @(posedge clk); #1;
    issue_ack_in = 1'b0;
    chk("b2b ack_at_release", W'(issue_ack_out), '0);
    chk("b2b valid_cleared", W'(quotient_valid_out), '0);
    @(posedge clk); #1;
    dividend_valid_in = 1'b0; divisor_valid_in = 1'b0;
    chk("b2b issue_ack", W'(issue_ack_out), W'(1));
    wait_result(W, "b2b");
    chk_result("b2b", v);

    // Reset while in DONE.
    @(negedge clk); reset_in = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("rst_done");
    @(negedge clk); reset_in = 1'b0;

    // Reset at iteration 30 aborts the operation with no result.
    issue(vecs[0], "abort");
    repeat (30) @(posedge clk);
    @(negedge clk); reset_in = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("abort");
    @(negedge clk); reset_in = 1'b0;
    seen = 1'b0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      seen |= quotient_valid_out | issue_ack_out;
    end
    chk("abort no_result", W'(seen), '0);

    v = mk(9, 0, 3, 0, 3, 0, 0, 0, 0);
    issue(v, "after_abort");
    wait_result(W, "after_abort");
    chk_result("after_abort", v);
    take_result("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_integer_divider

// File: doc/integer_divider.md
INTEGER_DIVIDER -- requirements
Module: integer_divider

Interface
REQ-001 SHALL have parameter OPERAND_WIDTH_IN_BITS, default 64, the width (W) of the dividend, divisor, quotient and remainder magnitudes.
REQ-002 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising clock edge.
REQ-003 clk_in  input  1  clock.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 dividend_valid_in  input  1  dividend operand present.
REQ-006 dividend_sign_in  input  1  dividend sign (1 = negative).
REQ-007 dividend_in  input  W  dividend magnitude.
REQ-008 divisor_valid_in  input  1  divisor operand present.
REQ-009 divisor_sign_in  input  1  divisor sign.
REQ-010 divisor_in  input  W  divisor magnitude.
REQ-011 issue_ack_out  output  1  one-cycle pulse, operands consumed.
REQ-012 quotient_valid_out  output  1  result available.
REQ-013 quotient_sign_out  output  1  quotient sign.
REQ-014 quotient_out  output  W  quotient magnitude.
REQ-015 remainder_sign_out  output  1  remainder sign.
REQ-016 remainder_out  output  W  remainder magnitude.
REQ-017 issue_ack_in  input  1  consumer accepts the result.
REQ-018 divide_exception_out  output  1  divide-by-zero flag, valid with quotient_valid_out.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-020 In IDLE, when dividend_valid_in and divisor_valid_in are both high at edge E0, SHALL capture both magnitudes and signs and pulse issue_ack_out high for exactly one cycle after E0.
REQ-021 SHALL ignore operand inputs in RUN and DONE; no second issue_ack_out pulse SHALL occur before the FSM returns to IDLE.
REQ-022 If the captured divisor is nonzero, SHALL enter RUN and perform one restoring shift-subtract step per cycle: shift the W+1-bit partial remainder left, bringing in the next dividend bit (MSB first); when the result is >= divisor, subtract and set the quotient bit to 1, otherwise set it to 0.
REQ-023 RUN SHALL last exactly W cycles, counted by an iteration counter; quotient_valid_out SHALL rise at edge E0+W+1.
REQ-024 If the captured divisor is zero, SHALL go directly to DONE; quotient_valid_out rises at E0+1, quotient_out = all ones, remainder_out = dividend magnitude, divide_exception_out = 1.
REQ-025 quotient_sign_out SHALL be dividend_sign XOR divisor_sign; remainder_sign_out SHALL be dividend_sign; both SHALL be forced to 0 when the corresponding magnitude is 0.
REQ-026 In DONE, all result outputs SHALL hold stable until issue_ack_in is sampled high.
REQ-027 On issue_ack_in high in DONE, SHALL clear all result outputs to 0 at that edge and return to IDLE; new operands are accepted no earlier than the following edge.
REQ-028 issue_ack_in SHALL be ignored outside DONE.

Reset
REQ-029 reset_in SHALL force IDLE, clear the counter and internal registers, and drive every output to 0 on the next edge, including mid-RUN and in DONE; the aborted operation SHALL produce no result.

Structure
REQ-030 FSM state encodings and the default operand width SHALL reside in the shared ALU package used by the arithmetic blocks.
REQ-031 The single-step compare/subtract SHALL be a combinational sub-module, integer_divider_step (W+1-bit partial remainder in; next partial remainder and quotient bit out).

Verification
REQ-032 100 / 7, both signs 0 -> issue_ack_out pulse at E0+1; at E0+65 quotient = 14, remainder = 2, exception = 0.
REQ-033 -100 / +7 -> quotient = 14 with sign 1; remainder = 2 with sign 1.
REQ-034 5 / 0 -> at E0+1 quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 5, exception = 1.
REQ-035 (2^64-1) / 1 -> quotient = all ones, remainder = 0; 3 / 9 -> quotient = 0 (sign 0), remainder = 3.
REQ-036 issue_ack_in held low 10 cycles after valid -> outputs unchanged; operands toggled in that window -> no issue_ack_out.
REQ-037 reset_in asserted at iteration 30 -> all outputs 0 next cycle; then 9 / 3 -> quotient = 3, remainder = 0.
